cpu_pio_switch_ctrl: RTL and testbench
======================================

// Module: cpu_pio_switch_ctrl
// PURPOSE
//  Avalon-MM slave controller for the board slide switches. Synchronises and
//  debounces in_port, tracks per-bit edges in a sticky edge-capture register,
//  and raises a maskable level IRQ to the Nios II.
//  Sits beside the plain switch PIO in the cpu system, on the same data bus.
// PARAMETERS
//  WIDTH            2      number of switch inputs (1..32)
//  DEBOUNCE_CYCLES  50000  consecutive stable clocks needed to accept a change (>=1; 1 ms at 50 MHz)
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  localparam, debounce counter width
// PORTS
//  clk        in   1      system clock; everything is on its rising edge
//  reset      in   1      synchronous, active-high reset
//  address    in   2      word address: 0=DATA 1=reserved 2=IRQMASK 3=EDGECAP
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe (qualified by chipselect)
//  writedata  in   32     write data; bits [WIDTH-1:0] used
//  readdata   out  32     registered read data, zero-extended
//  in_port    in   WIDTH  raw asynchronous switch inputs
//  irq        out  1      level interrupt = |(edgecap & irqmask)
// BEHAVIOUR
//  - Reset (reset=1 on a clk edge): sync FFs, stable, counters, irqmask, edgecap
//    and readdata all go to 0; irq goes to 0. Reset mid-debounce discards the count.
//  - Sync: 2-FF synchroniser per bit -> s[i].
//  - Debounce, per bit: while s[i]==stable[i], cnt=0. While they differ, cnt
//    increments. On the clock where cnt==DEBOUNCE_CYCLES-1 and they still
//    differ: stable[i]<=s[i], cnt<=0. A single matching cycle restarts the count.
//    in_port -> stable latency = DEBOUNCE_CYCLES+2 clocks.
//  - Edge: edge[i] = stable[i] ^ stable_d[i], any direction. On the next clock,
//    edgecap[i] <= 1 (sticky).
//  - EDGECAP write (chipselect & ~write_n & address==3): each writedata bit = 1
//    clears the matching edgecap bit. If a set and a clear hit the same bit in
//    the same cycle, the set wins.
//  - IRQMASK write (address==2): irqmask <= writedata[WIDTH-1:0].
//  - DATA (0) and reserved (1): writes are ignored.
//  - irq is combinational from registers: it rises in the same cycle edgecap
//    and irqmask overlap, and falls in the cycle after the clearing write.
//  - Read: readdata is registered every clock (read latency 1, no read strobe):
//    addr 0 -> stable, addr 1 -> 0, addr 2 -> irqmask, addr 3 -> edgecap;
//    upper bits are 0. Reads have no side effects.
//  - After reset, stable=0. A switch held high produces one rising edge after
//    debounce. irqmask=0 at reset, so that edge does not raise irq.
// CONFIGURATION
//  SWITCH_DEBOUNCE_EN defined: the debounce counter is built as described above.
//  SWITCH_DEBOUNCE_EN undefined: no counter; stable <= s every clock (behaves as
//    DEBOUNCE_CYCLES=1); latency = 3 clocks; DEBOUNCE_CYCLES is ignored.
// STRUCTURE
//  - Package cpu_pio_pkg: register address constants PIO_ADDR_DATA=0,
//    PIO_ADDR_IRQMASK=2, PIO_ADDR_EDGECAP=3, and the 32-bit bus width constant.
//  - Sub-module cpu_switch_debounce: one bit, holding the synchroniser, counter
//    and stable FF. Instantiated WIDTH times in a generate loop.
//  - The top level holds edge detect, edgecap, irqmask, the read mux and irq.
// TESTING (bench uses DEBOUNCE_CYCLES=4, WIDTH=2, SWITCH_DEBOUNCE_EN defined)
//  1 Reset with in_port=2'b11, release reset -> readdata=0 and irq=0 during reset;
//    DATA reads 3 six clocks after release; EDGECAP reads 3; irq stays 0.
//  2 Bounce: in_port[0] toggles 0/1 every 2 clocks for 20 clocks, then settles at 1
//    -> DATA bit0 stays 0 during the toggling and becomes 1 exactly 6 clocks after
//    settling; exactly one edgecap bit0 set.
//  3 Write IRQMASK=1, write EDGECAP=3 to clear, then press bit0 -> irq rises 1 clock
//    after DATA changes; write EDGECAP=1 -> irq falls the next clock.
//  4 Same-cycle edge on bit1 and EDGECAP write of 2 -> edgecap bit1 remains 1.
//  5 Reset asserted mid-debounce (cnt=2) -> after release, debounce restarts from 0
//    and takes a full 4 stable cycles.
//  6 Undefine SWITCH_DEBOUNCE_EN: in_port 0->1 -> DATA reads 1 after 3 clocks; a
//    1-clock glitch is visible in DATA.

Source files
------------

// File: rtl/cpu_pio_pkg.sv
// Shared constants for the cpu PIO switch controller: Avalon-MM register map
// word addresses and the data bus width.
package cpu_pio_pkg;

  localparam int unsigned PIO_BUS_W = 32;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

endpackage : cpu_pio_pkg

// File: rtl/cpu_switch_debounce.sv
// One-bit switch conditioner: 2-FF synchroniser followed by a debounce stage.
// Build option SWITCH_DEBOUNCE_EN: when defined, a change is accepted only
// after DEBOUNCE_CYCLES consecutive differing samples; when undefined the
// synchronised value is taken every clock and DEBOUNCE_CYCLES is ignored.
module cpu_switch_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic sync1_r;
  logic sync2_r;
  logic stable_r;

  // Two-stage synchroniser for the asynchronous switch input.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= raw;
      sync2_r <= sync1_r;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] cnt_r;

  // Count consecutive mismatches; any matching sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r    <= '0;
      stable_r <= 1'b0;
    end else if (sync2_r == stable_r) begin
      cnt_r    <= '0;
      stable_r <= stable_r;
    end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      cnt_r    <= '0;
      stable_r <= sync2_r;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1);
      stable_r <= stable_r;
    end
  end
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;

  // Without debounce the synchronised sample is accepted every clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_r <= 1'b0;
    end else begin
      stable_r <= sync2_r;
    end
  end
`endif

  assign stable = stable_r;

endmodule : cpu_switch_debounce

// File: rtl/cpu_pio_switch_ctrl.sv
// Avalon-MM slave for the board slide switches: per-bit synchronise and
// debounce, sticky any-direction edge capture, maskable level IRQ.
// Build option SWITCH_DEBOUNCE_EN enables the debounce counters (see
// cpu_switch_debounce); without it changes pass after the synchroniser.
module cpu_pio_switch_ctrl
  import cpu_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [PIO_BUS_W-1:0] writedata,
  output logic [PIO_BUS_W-1:0] readdata,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  logic [WIDTH-1:0]     stable_s;
  logic [WIDTH-1:0]     stable_d_r;
  logic [WIDTH-1:0]     edge_s;
  logic [WIDTH-1:0]     clr_s;
  logic [WIDTH-1:0]     edgecap_r;
  logic [WIDTH-1:0]     irqmask_r;
  logic [PIO_BUS_W-1:0] rd_next_s;
  logic [PIO_BUS_W-1:0] readdata_r;
  logic                 wr_s;

  // Only the low WIDTH write bits are register content.
  logic unused_writedata_s;
  assign unused_writedata_s = &{1'b0, writedata};

  assign wr_s = chipselect & ~write_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cpu_switch_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (in_port[i]),
      .stable(stable_s[i])
    );
  end

  // Delayed copy of the debounced value for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      stable_d_r <= '0;
    end else begin
      stable_d_r <= stable_s;
    end
  end

  // Edge strobe and write-one-to-clear mask for the capture register.
  always_comb begin
    edge_s = stable_s ^ stable_d_r;
    clr_s  = '0;
    if (wr_s && (address == PIO_ADDR_EDGECAP)) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
  end

  // Sticky edge capture; a new edge beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      edgecap_r <= '0;
    end else begin
      edgecap_r <= (edgecap_r & ~clr_s) | edge_s;
    end
  end

  // Interrupt mask register, written at its word address.
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask_r <= '0;
    end else if (wr_s && (address == PIO_ADDR_IRQMASK)) begin
      irqmask_r <= writedata[WIDTH-1:0];
    end else begin
      irqmask_r <= irqmask_r;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_next_s = '0;
    case (address)
      PIO_ADDR_DATA:    rd_next_s[WIDTH-1:0] = stable_s;
      PIO_ADDR_RSVD:    rd_next_s = '0;
      PIO_ADDR_IRQMASK: rd_next_s[WIDTH-1:0] = irqmask_r;
      PIO_ADDR_EDGECAP: rd_next_s[WIDTH-1:0] = edgecap_r;
      default:          rd_next_s = '0;
    endcase
  end

  // Read data is registered every clock; reads have no side effects.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r <= '0;
    end else begin
      readdata_r <= rd_next_s;
    end
  end

  assign readdata = readdata_r;
  assign irq      = |(edgecap_r & irqmask_r);

endmodule : cpu_pio_switch_ctrl

// File: tb/tb_cpu_pio_switch_ctrl.sv
// Scoreboard bench for cpu_pio_switch_ctrl (WIDTH=2, DEBOUNCE_CYCLES=4).
// Expected readdata/irq per clock are queued by the stimulus process and
// popped by an independent negedge monitor; directed checks add fixed values.
module tb_cpu_pio_switch_ctrl;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int DB_EFF = 4;
`else
  localparam int DB_EFF = 1;
`endif
  localparam int LAT = DB_EFF + 2;
  localparam logic [31:0] GLITCH_SEEN = (DB_EFF == 1) ? 32'd1 : 32'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  in_port;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        irq;
  } exp_t;
  exp_t exp_q[$];

  // reference state
  logic [1:0]  m_sync1 = 2'b00, m_sync2 = 2'b00, m_st = 2'b00, m_std = 2'b00;
  logic [1:0]  m_ec = 2'b00, m_mask = 2'b00;
  logic [31:0] m_rd = 32'd0;
  int          m_last[2];
  int          cyc = 0;

  cpu_pio_switch_ctrl #(
    .WIDTH(2),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a bit flips once it has disagreed with the accepted
  // value for DB_EFF consecutive sampling edges since the last agreement.
  task automatic model_edge();
    logic [1:0] s_o, st_o, std_o, ec_o, mask_o, clr;
    cyc++;
    if (reset) begin
      m_sync1 = 2'b00; m_sync2 = 2'b00; m_st = 2'b00; m_std = 2'b00;
      m_ec = 2'b00; m_mask = 2'b00; m_rd = 32'd0;
      m_last[0] = cyc; m_last[1] = cyc;
    end else begin
      s_o = m_sync2; st_o = m_st; std_o = m_std; ec_o = m_ec; mask_o = m_mask;
      for (int i = 0; i < 2; i++) begin
        if (s_o[i] == st_o[i]) m_last[i] = cyc;
        else if (cyc - m_last[i] >= DB_EFF) begin
          m_st[i] = s_o[i];
          m_last[i] = cyc;
        end
      end
      m_sync2 = m_sync1;
      m_sync1 = in_port;
      m_std = st_o;
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[1:0] : 2'b00;
      m_ec = (ec_o & ~clr) | (st_o ^ std_o);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[1:0];
      case (address)
        2'd0:    m_rd = {30'd0, st_o};
        2'd2:    m_rd = {30'd0, mask_o};
        2'd3:    m_rd = {30'd0, ec_o};
        default: m_rd = 32'd0;
      endcase
    end
    exp_q.push_back('{rd: m_rd, irq: |(m_ec & m_mask)});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = 32'd0;
  endtask

  // Monitor: one expectation per clock, compared away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("sb_readdata", readdata, e.rd);
      check("sb_irq", {31'd0, irq}, {31'd0, e.irq});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    writedata = 32'd0; in_port = 2'b11;
    m_last[0] = 0; m_last[1] = 0;

    // 1: reset with switches high
    repeat (3) tick();
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    repeat (LAT) tick();
    check("t1_data_pre", readdata, 32'd0);
    tick();
    check("t1_data", readdata, 32'd3);
    address = 2'd3;
    tick();
    check("t1_edgecap", readdata, 32'd3);
    check("t1_irq", {31'd0, irq}, 32'd0);

    // 2: bounce on bit0, then settle high
    in_port = 2'b10;
    repeat (LAT + 2) tick();
    bus_write(2'd3, 32'd3);
    address = 2'd0;
    for (int k = 0; k < 10; k++) begin
      in_port[0] = ~in_port[0];
      repeat (2) tick();
    end
    in_port[0] = 1'b1;
    repeat (LAT + 1) tick();
    check("t2_settle", {31'd0, readdata[0]}, 32'd1);
    address = 2'd3;
    tick();
    check("t2_edgecap", readdata, 32'd1);

    // 3: masked irq rise and clear
    bus_write(2'd2, 32'd1);
    bus_write(2'd3, 32'd3);
    address = 2'd0;
    in_port[0] = 1'b0;
    repeat (LAT) tick();
    check("t3_irq_pre", {31'd0, irq}, 32'd0);
    tick();
    check("t3_irq_rise", {31'd0, irq}, 32'd1);
    bus_write(2'd3, 32'd1);
    check("t3_irq_fall", {31'd0, irq}, 32'd0);

    // writes to DATA and reserved are ignored
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd1;
    tick();
    check("rsvd_read", readdata, 32'd0);
    address = 2'd2;
    tick();
    check("mask_kept", readdata, 32'd1);

    // 4: edge on bit1 coinciding with a clear of bit1
    bus_write(2'd2, 32'd2);
    in_port[1] = 1'b0;
    repeat (LAT) tick();
    bus_write(2'd3, 32'd2);
    tick();
    check("t4_edgecap", {31'd0, readdata[1]}, 32'd1);
    check("t4_irq", {31'd0, irq}, 32'd1);

    // 5: reset in the middle of a debounce
    address = 2'd0;
    in_port[0] = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (LAT) tick();
    check("t5_pre", readdata, 32'd0);
    tick();
    check("t5_post", readdata, 32'd1);

    // 6: one-clock glitch on bit0
    in_port = 2'b00;
    repeat (LAT + 2) tick();
    in_port[0] = 1'b1;
    tick();
    in_port[0] = 1'b0;
    repeat (3) tick();
    check("t6_glitch", {31'd0, readdata[0]}, GLITCH_SEEN);
    tick();
    check("t6_after", {31'd0, readdata[0]}, 32'd0);

    @(negedge clk);
    #1;
    check("sb_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cpu_pio_switch_ctrl
